pc_jump_sequencer: RTL and testbench

PC_JUMP_SEQUENCER -- requirements
Module: pc_jump_sequencer

---
 rtl/pc_jump_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pc_jump_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_jump_sequencer.sv
// pc_jump_sequencer: turns jump/call/return requests into the byte-wide
// strobe sequence that reloads the program counter, and keeps a 4-deep
// return-address stack for CALL/RET.
module pc_jump_sequencer (
    input  logic        clk,
    input  logic        MR,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [2:0]  cond,
    input  logic [3:0]  flags,
    input  logic [15:0] target,
    input  logic [7:0]  pchi,
    input  logic [7:0]  pclo,
    output logic [7:0]  D,
    output logic        _pchitmp_in,
    output logic        _long_jump,
    output logic        _local_jump,
    output logic        ack,
    output logic        taken,
    output logic        err,
    output logic        busy,
    output logic [2:0]  depth
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        JUMP_LONG,
        JUMP_LOCAL,
        DONE
    } state_t;

    localparam logic [1:0] OP_JMP_LOCAL = 2'd0;
    localparam logic [1:0] OP_JMP_LONG  = 2'd1;
    localparam logic [1:0] OP_CALL      = 2'd2;
    localparam logic [1:0] OP_RET       = 2'd3;

    state_t      state, state_n;
    logic [15:0] addr_q, addr_n;
    logic [2:0]  depth_n;
    logic [15:0] ret_stack [0:3];
    logic [1:0]  top_idx;
    logic [15:0] ret_addr;
    logic [15:0] pc_inc;
    logic        push_en;
    logic        cond_true;
    logic [7:0]  d_n;
    logic        pchitmp_n, long_n, local_n;
    logic        ack_n, taken_n, err_n;

    // Depth of 4 aliases to index 0 in two bits, so top-of-stack is always depth-1.
    assign top_idx  = depth[1:0] - 2'd1;
    assign ret_addr = ret_stack[top_idx];
    assign pc_inc   = {pchi, pclo} + 16'd1;

    // Decode the condition code against the flags presented with the request.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'd0:    cond_true = 1'b1;
            3'd1:    cond_true = flags[0];
            3'd2:    cond_true = !flags[0];
            3'd3:    cond_true = flags[1];
            3'd4:    cond_true = !flags[1];
            3'd5:    cond_true = flags[2];
            3'd6:    cond_true = flags[3];
            default: cond_true = 1'b0;
        endcase
    end

    // Next state, stack action and the output values that will be registered
    // alongside the next state, so every output is a flop.
    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        depth_n   = depth;
        push_en   = 1'b0;
        d_n       = 8'h00;
        pchitmp_n = 1'b1;
        long_n    = 1'b1;
        local_n   = 1'b1;
        ack_n     = 1'b0;
        taken_n   = 1'b0;
        err_n     = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    addr_n = target;
                    if (!cond_true) begin
                        state_n = DONE;
                    end else begin
                        case (op)
                            OP_JMP_LOCAL: state_n = JUMP_LOCAL;
                            OP_JMP_LONG:  state_n = LOAD_HI;
                            OP_CALL: begin
                                if (depth == 3'd4) begin
                                    state_n = DONE;
                                    err_n   = 1'b1;
                                end else begin
                                    push_en = 1'b1;
                                    depth_n = depth + 3'd1;
                                    state_n = LOAD_HI;
                                end
                            end
                            default: begin
                                if (depth == 3'd0) begin
                                    state_n = DONE;
                                    err_n   = 1'b1;
                                end else begin
                                    addr_n  = ret_addr;
                                    depth_n = depth - 3'd1;
                                    state_n = LOAD_HI;
                                end
                            end
                        endcase
                    end
                end
            end
            LOAD_HI:    state_n = JUMP_LONG;
            JUMP_LONG: begin
                state_n = DONE;
                taken_n = 1'b1;
            end
            JUMP_LOCAL: begin
                state_n = DONE;
                taken_n = 1'b1;
            end
            DONE:       state_n = IDLE;
            default:    state_n = IDLE;
        endcase

        case (state_n)
            LOAD_HI: begin
                d_n       = addr_n[15:8];
                pchitmp_n = 1'b0;
            end
            JUMP_LONG: begin
                d_n    = addr_n[7:0];
                long_n = 1'b0;
            end
            JUMP_LOCAL: begin
                d_n     = addr_n[7:0];
                local_n = 1'b0;
            end
            DONE:    ack_n = 1'b1;
            default: ack_n = 1'b0;
        endcase
    end

    // State, captured address, stack pointer and registered outputs.
    always_ff @(posedge clk or posedge MR) begin
        if (MR) begin
            state       <= IDLE;
            addr_q      <= 16'h0000;
            depth       <= 3'd0;
            D           <= 8'h00;
            _pchitmp_in <= 1'b1;
            _long_jump  <= 1'b1;
            _local_jump <= 1'b1;
            ack         <= 1'b0;
            taken       <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            addr_q      <= addr_n;
            depth       <= depth_n;
            D           <= d_n;
            _pchitmp_in <= pchitmp_n;
            _long_jump  <= long_n;
            _local_jump <= local_n;
            ack         <= ack_n;
            taken       <= taken_n & ack_n;
            err         <= err_n & ack_n;
            busy        <= (state_n != IDLE);
        end
    end

    // Return-address storage; the slot at the current depth takes the pushed PC+1.
    always_ff @(posedge clk or posedge MR) begin
        if (MR) begin
            for (int i = 0; i < 4; i++) begin
                ret_stack[i] <= 16'h0000;
            end
        end else if (push_en) begin
            ret_stack[depth[1:0]] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_jump_sequencer.sv
// tb_pc_jump_sequencer: directed vectors with a scoreboard of expected
// strobe/ack events, popped and compared by an independent monitor.
module tb_pc_jump_sequencer;

    localparam logic [2:0] K_HI    = 3'd0;
    localparam logic [2:0] K_LONG  = 3'd1;
    localparam logic [2:0] K_LOCAL = 3'd2;
    localparam logic [2:0] K_ACK   = 3'd3;
    localparam logic [2:0] K_NONE  = 3'd6;
    localparam logic [2:0] K_BAD   = 3'd7;

    typedef struct {
        logic [2:0]  kind;
        logic [7:0]  d;
        logic        tk;
        logic        er;
        logic [2:0]  dp;
        logic        chk_pc;
        logic [15:0] pc;
        int          id;
    } ev_t;

    logic        clk = 1'b0;
    logic        MR = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [2:0]  cond = 3'd0;
    logic [3:0]  flags = 4'd0;
    logic [15:0] target = 16'h0000;
    logic [7:0]  pchi = 8'h00;
    logic [7:0]  pclo = 8'h00;
    logic [7:0]  D;
    logic        _pchitmp_in, _long_jump, _local_jump;
    logic        ack, taken, err, busy;
    logic [2:0]  depth;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  hi_tmp = 8'h00;
    logic [15:0] jpc = 16'h0000;
    logic [2:0]  mon_k;
    int          mon_lows;
    ev_t         mon_e;

    pc_jump_sequencer dut (
        .clk         (clk),
        .MR          (MR),
        .req         (req),
        .op          (op),
        .cond        (cond),
        .flags       (flags),
        .target      (target),
        .pchi        (pchi),
        .pclo        (pclo),
        .D           (D),
        ._pchitmp_in (_pchitmp_in),
        ._long_jump  (_long_jump),
        ._local_jump (_local_jump),
        .ack         (ack),
        .taken       (taken),
        .err         (err),
        .busy        (busy),
        .depth       (depth)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Program-counter model: loads from the strobes the way the real PC would.
    always @(posedge clk) begin
        if (!_pchitmp_in) hi_tmp <= D;
        if (!_long_jump) jpc <= {hi_tmp, D};
        if (!_local_jump) jpc <= {pchi, D};
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic pushEv(input logic [2:0] k, input logic [7:0] d, input logic tk,
                          input logic er, input logic [2:0] dp, input logic chk,
                          input logic [15:0] pc, input int id);
        ev_t e;
        e.kind = k; e.d = d; e.tk = tk; e.er = er; e.dp = dp;
        e.chk_pc = chk; e.pc = pc; e.id = id;
        exp_q.push_back(e);
    endtask

    // Queue the events a request should produce, given hand-computed results.
    task automatic expectSeq(input logic [1:0] o, input logic exp_taken, input logic exp_err,
                             input logic [2:0] exp_depth, input logic [15:0] exp_addr,
                             input int id);
        if (exp_taken) begin
            if (o == 2'd0) begin
                pushEv(K_LOCAL, exp_addr[7:0], 1'b0, 1'b0, exp_depth, 1'b0, 16'h0, id);
            end else begin
                pushEv(K_HI, exp_addr[15:8], 1'b0, 1'b0, exp_depth, 1'b0, 16'h0, id);
                pushEv(K_LONG, exp_addr[7:0], 1'b0, 1'b0, exp_depth, 1'b0, 16'h0, id);
            end
        end
        pushEv(K_ACK, 8'h00, exp_taken, exp_err, exp_depth, exp_taken, exp_addr, id);
    endtask

    task automatic waitDrain(input int id);
        for (int i = 0; i < 12; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL v%0d_timeout: %0d events outstanding, expected 0", id, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [2:0] c, input logic [3:0] f,
                                 input logic [15:0] t, input logic [7:0] ph, input logic [7:0] pl,
                                 input logic exp_taken, input logic exp_err,
                                 input logic [2:0] exp_depth, input logic [15:0] exp_addr,
                                 input int id);
        expectSeq(o, exp_taken, exp_err, exp_depth, exp_addr, id);
        @(negedge clk);
        op = o; cond = c; flags = f; target = t; pchi = ph; pclo = pl; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        waitDrain(id);
    endtask

    // Monitor: classify each cycle's outputs and compare against the scoreboard.
    always @(negedge clk) begin
        if (!MR) begin
            mon_lows = (_pchitmp_in ? 0 : 1) + (_long_jump ? 0 : 1) + (_local_jump ? 0 : 1);
            if (mon_lows > 1 || (mon_lows == 1 && ack)) mon_k = K_BAD;
            else if (!_pchitmp_in) mon_k = K_HI;
            else if (!_long_jump) mon_k = K_LONG;
            else if (!_local_jump) mon_k = K_LOCAL;
            else if (ack) mon_k = K_ACK;
            else mon_k = K_NONE;

            if (mon_k == K_NONE) begin
                checkOutput("d_idle", {8'h00, D}, 16'h0000);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got kind %0d D=%h, expected no event", mon_k, D);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput($sformatf("v%0d_kind", mon_e.id), {13'd0, mon_k}, {13'd0, mon_e.kind});
                checkOutput($sformatf("v%0d_D", mon_e.id), {8'h00, D}, {8'h00, mon_e.d});
                checkOutput($sformatf("v%0d_depth", mon_e.id), {13'd0, depth}, {13'd0, mon_e.dp});
                if (mon_e.kind == K_ACK) begin
                    checkOutput($sformatf("v%0d_taken", mon_e.id), {15'd0, taken}, {15'd0, mon_e.tk});
                    checkOutput($sformatf("v%0d_err", mon_e.id), {15'd0, err}, {15'd0, mon_e.er});
                    if (mon_e.chk_pc) checkOutput($sformatf("v%0d_pc", mon_e.id), jpc, mon_e.pc);
                end
            end
        end
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "[TB] global timeout");
    end

    // Directed stimulus.
    initial begin
        #1 MR = 1'b1;
        #1;
        checkOutput("rst_D", {8'h00, D}, 16'h0000);
        checkOutput("rst_pchitmp", {15'd0, _pchitmp_in}, 16'd1);
        checkOutput("rst_long", {15'd0, _long_jump}, 16'd1);
        checkOutput("rst_local", {15'd0, _local_jump}, 16'd1);
        checkOutput("rst_ack", {15'd0, ack}, 16'd0);
        checkOutput("rst_taken", {15'd0, taken}, 16'd0);
        checkOutput("rst_err", {15'd0, err}, 16'd0);
        checkOutput("rst_busy", {15'd0, busy}, 16'd0);
        checkOutput("rst_depth", {13'd0, depth}, 16'd0);
        repeat (2) @(posedge clk);
        #1 MR = 1'b0;

        // Unconditional long jump to ff:aa.
        applyStimulus(2'd1, 3'd0, 4'b0000, 16'hffaa, 8'h01, 8'h00, 1'b1, 1'b0, 3'd0, 16'hffaa, 1);
        // Local jump on Z with Z clear: not taken.
        applyStimulus(2'd0, 3'd1, 4'b0000, 16'h0012, 8'h30, 8'h00, 1'b0, 1'b0, 3'd0, 16'h0000, 2);
        // Local jump on !Z with Z clear: taken, high byte kept from PC.
        applyStimulus(2'd0, 3'd2, 4'b0000, 16'h0012, 8'h30, 8'h05, 1'b1, 1'b0, 3'd0, 16'h3012, 3);
        // Long jump on C with C set.
        applyStimulus(2'd1, 3'd3, 4'b0010, 16'h1357, 8'h30, 8'h05, 1'b1, 1'b0, 3'd0, 16'h1357, 4);
        // Long jump on !C with C set: not taken.
        applyStimulus(2'd1, 3'd4, 4'b0010, 16'h2468, 8'h30, 8'h05, 1'b0, 1'b0, 3'd0, 16'h0000, 5);
        // Local jump on O with O set, and "never".
        applyStimulus(2'd0, 3'd6, 4'b1000, 16'h00c3, 8'h44, 8'h00, 1'b1, 1'b0, 3'd0, 16'h44c3, 6);
        applyStimulus(2'd1, 3'd7, 4'b1111, 16'h9999, 8'h44, 8'h00, 1'b0, 1'b0, 3'd0, 16'h0000, 7);

        // Four CALLs fill the stack, the fifth faults.
        applyStimulus(2'd2, 3'd0, 4'b0000, 16'h5600, 8'h12, 8'h34, 1'b1, 1'b0, 3'd1, 16'h5600, 8);
        applyStimulus(2'd2, 3'd0, 4'b0000, 16'h5600, 8'h12, 8'h44, 1'b1, 1'b0, 3'd2, 16'h5600, 9);
        applyStimulus(2'd2, 3'd0, 4'b0000, 16'h5600, 8'h12, 8'h54, 1'b1, 1'b0, 3'd3, 16'h5600, 10);
        applyStimulus(2'd2, 3'd0, 4'b0000, 16'h5600, 8'h12, 8'h64, 1'b1, 1'b0, 3'd4, 16'h5600, 11);
        applyStimulus(2'd2, 3'd0, 4'b0000, 16'h5600, 8'h12, 8'h74, 1'b0, 1'b1, 3'd4, 16'h0000, 12);
        // RETs unwind in LIFO order.
        applyStimulus(2'd3, 3'd0, 4'b0000, 16'h0000, 8'h56, 8'h10, 1'b1, 1'b0, 3'd3, 16'h1265, 13);
        applyStimulus(2'd3, 3'd0, 4'b0000, 16'h0000, 8'h56, 8'h10, 1'b1, 1'b0, 3'd2, 16'h1255, 14);
        applyStimulus(2'd3, 3'd0, 4'b0000, 16'h0000, 8'h56, 8'h10, 1'b1, 1'b0, 3'd1, 16'h1245, 15);
        applyStimulus(2'd3, 3'd0, 4'b0000, 16'h0000, 8'h56, 8'h10, 1'b1, 1'b0, 3'd0, 16'h1235, 16);
        // RET on an empty stack faults.
        applyStimulus(2'd3, 3'd0, 4'b0000, 16'h0000, 8'h56, 8'h10, 1'b0, 1'b1, 3'd0, 16'h0000, 17);
        // CALL from ffff pushes 0000.
        applyStimulus(2'd2, 3'd0, 4'b0000, 16'h2000, 8'hff, 8'hff, 1'b1, 1'b0, 3'd1, 16'h2000, 18);
        applyStimulus(2'd3, 3'd0, 4'b0000, 16'h0000, 8'h20, 8'h00, 1'b1, 1'b0, 3'd0, 16'h0000, 19);

        // Reset pulse while in LOAD_HI of a CALL.
        @(negedge clk);
        op = 2'd2; cond = 3'd0; flags = 4'b0000; target = 16'h7777; pchi = 8'h40; pclo = 8'h00;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        checkOutput("mr_pre_depth", {13'd0, depth}, 16'd1);
        checkOutput("mr_pre_pchitmp", {15'd0, _pchitmp_in}, 16'd0);
        #1 MR = 1'b1;
        #1;
        checkOutput("mr_pchitmp", {15'd0, _pchitmp_in}, 16'd1);
        checkOutput("mr_long", {15'd0, _long_jump}, 16'd1);
        checkOutput("mr_local", {15'd0, _local_jump}, 16'd1);
        checkOutput("mr_D", {8'h00, D}, 16'h0000);
        checkOutput("mr_depth", {13'd0, depth}, 16'd0);
        checkOutput("mr_busy", {15'd0, busy}, 16'd0);
        repeat (2) @(posedge clk);
        #1 MR = 1'b0;
        repeat (6) @(negedge clk);
        // First request after reset is accepted normally.
        applyStimulus(2'd3, 3'd0, 4'b0000, 16'h0000, 8'h40, 8'h00, 1'b0, 1'b1, 3'd0, 16'h0000, 20);

        // req held high through two acceptances of a long jump.
        expectSeq(2'd1, 1'b1, 1'b0, 3'd0, 16'h0abc, 21);
        expectSeq(2'd1, 1'b1, 1'b0, 3'd0, 16'h0abc, 22);
        @(negedge clk);
        op = 2'd1; cond = 3'd0; flags = 4'b0000; target = 16'h0abc; pchi = 8'h01; pclo = 8'h00;
        req = 1'b1;
        @(posedge clk);
        #1 checkOutput("hold_busy_e0", {15'd0, busy}, 16'd1);
        repeat (3) @(posedge clk);
        #1 checkOutput("hold_busy_e3", {15'd0, busy}, 16'd0);
        @(posedge clk);
        #1 checkOutput("hold_busy_e4", {15'd0, busy}, 16'd1);
        req = 1'b0;
        waitDrain(22);
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
